// File: rtl/pc_redirect_unit_pkg.sv
// Shared core types: address/data words and the branch-type encoding used by EX and fetch.
package CorePack;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] data_t;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } br_type_enum;

    localparam addr_t FETCH_STRIDE = 64'd4;
endpackage

// File: rtl/pc_redirect_unit_target.sv
// Branch/jump target generator: pc-relative for COND/JAL, register-relative with bit 0 cleared for JALR.
module pc_target_gen
    import CorePack::*;
(
    input  br_type_enum br_type,
    input  addr_t       ex_pc,
    input  data_t       ex_rs1,
    input  data_t       ex_imm,
    output addr_t       target,
    output logic        misalign
);
    always_comb begin
        target = ex_pc + ex_imm;
        if (br_type == BR_JALR) begin
            target = (ex_rs1 + ex_imm) & ~64'h1;
        end
        misalign = target[1];
    end
endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch-PC owner: issues imem requests, resolves EX branches (predict not-taken) into flush + redirect.
// Optional BRANCH_PERF_EN adds br_cnt/taken_cnt counters.
module pc_redirect_unit
    import CorePack::*;
#(
    parameter addr_t RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output addr_t       imem_req_addr,
    input  logic        ex_valid,
    input  logic        backend_stall,
    input  br_type_enum ex_br_type,
    input  logic        ex_cmp_res,
    input  addr_t       ex_pc,
    input  data_t       ex_imm,
    input  data_t       ex_rs1,
    output logic        flush,
    output addr_t       redirect_pc,
    output logic        redirect_misalign,
    output logic        stale_accept
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt
`endif
);
    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_FETCH      = 2'd1,
        ST_REDIR_WAIT = 2'd2
    } state_e;

    state_e state_q, state_d;
    addr_t  pc_q, pc_d;
    addr_t  pending_q, pending_d;

    addr_t  target;
    logic   target_mis;
    logic   ex_fire;
    logic   taken;
    logic   accept;

    pc_target_gen u_target (
        .br_type  (ex_br_type),
        .ex_pc    (ex_pc),
        .ex_rs1   (ex_rs1),
        .ex_imm   (ex_imm),
        .target   (target),
        .misalign (target_mis)
    );

    always_comb begin
        ex_fire = ex_valid & ~backend_stall;
        taken   = rstn & ex_fire &
                  ((ex_br_type == BR_JAL) | (ex_br_type == BR_JALR) |
                   ((ex_br_type == BR_COND) & ex_cmp_res));
        imem_req_valid = rstn;
        accept         = imem_req_valid & imem_req_ready;

        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = pending_q;
        stale_accept = 1'b0;

        case (state_q)
            ST_REDIR_WAIT: begin
                if (taken) begin
                    pending_d = target;
                end
                // The old address is finally accepted; its response is wrong-path.
                if (accept) begin
                    stale_accept = 1'b1;
                    pc_d         = taken ? target : pending_q;
                    state_d      = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
                if (taken && imem_req_ready) begin
                    pc_d = target;
                end else if (taken) begin
                    pending_d = target;
                    state_d   = ST_REDIR_WAIT;
                end else if (accept) begin
                    pc_d = pc_q + FETCH_STRIDE;
                end
            end
        endcase

        imem_req_addr     = rstn ? pc_q : RESET_PC;
        flush             = taken;
        redirect_pc       = taken ? target : '0;
        redirect_misalign = taken & target_mis;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_RESET;
            pc_q      <= RESET_PC;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
        end
    end

`ifdef BRANCH_PERF_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_comb begin
        br_cnt_d    = br_cnt_q + {31'd0, ex_fire & (ex_br_type != BR_NONE)};
        taken_cnt_d = taken_cnt_q + {31'd0, taken};
        br_cnt      = br_cnt_q;
        taken_cnt   = taken_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: branch vector table plus hand sequences; accepted fetches go through a scoreboard.
module tb_pc_redirect_unit;
    import CorePack::*;

    logic        clk;
    logic        rstn;
    logic        imem_req_valid;
    logic        imem_req_ready;
    addr_t       imem_req_addr;
    logic        ex_valid;
    logic        backend_stall;
    br_type_enum ex_br_type;
    logic        ex_cmp_res;
    addr_t       ex_pc;
    data_t       ex_imm;
    data_t       ex_rs1;
    logic        flush;
    addr_t       redirect_pc;
    logic        redirect_misalign;
    logic        stale_accept;
`ifdef BRANCH_PERF_EN
    logic [31:0] br_cnt;
    logic [31:0] taken_cnt;
`endif

    pc_redirect_unit #(.RESET_PC(64'h0)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .ex_valid          (ex_valid),
        .backend_stall     (backend_stall),
        .ex_br_type        (ex_br_type),
        .ex_cmp_res        (ex_cmp_res),
        .ex_pc             (ex_pc),
        .ex_imm            (ex_imm),
        .ex_rs1            (ex_rs1),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .redirect_misalign (redirect_misalign),
        .stale_accept      (stale_accept)
`ifdef BRANCH_PERF_EN
        ,
        .br_cnt            (br_cnt),
        .taken_cnt         (taken_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        br_type_enum t;
        logic        cmp;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] rs1;
        logic        exp_flush;
        logic [63:0] exp_rpc;
        logic        exp_mis;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic        stale;
    } acc_t;

    vec_t        vecs[7];
    acc_t        exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] mpc;
    int          flush_seen;
`ifdef BRANCH_PERF_EN
    logic [31:0] br0, tk0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] a, input logic s);
        acc_t e;
        e.addr  = a;
        e.stale = s;
        exp_q.push_back(e);
    endtask

    // Sample point: negedge. Any accepted request is checked against the scoreboard.
    task automatic sample();
        acc_t e;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: accept of %h with nothing expected", imem_req_addr);
            end else begin
                e = exp_q.pop_front();
                chk("sb_addr", imem_req_addr, e.addr);
                chk("sb_stale", {63'd0, stale_accept}, {63'd0, e.stale});
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input br_type_enum t, input logic c,
                          input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] rs1);
        ex_valid   = v;
        ex_br_type = t;
        ex_cmp_res = c;
        ex_pc      = pc;
        ex_imm     = imm;
        ex_rs1     = rs1;
    endtask

    initial begin
        vecs[0] = '{BR_COND, 1'b1, 64'h100, 64'h20, 64'h0, 1'b1, 64'h120, 1'b0};
        vecs[1] = '{BR_COND, 1'b0, 64'h100, 64'h20, 64'h0, 1'b0, 64'h0, 1'b0};
        vecs[2] = '{BR_NONE, 1'b1, 64'h100, 64'h20, 64'h0, 1'b0, 64'h0, 1'b0};
        vecs[3] = '{BR_JALR, 1'b0, 64'h40, 64'h4, 64'h301, 1'b1, 64'h304, 1'b0};
        vecs[4] = '{BR_JALR, 1'b0, 64'h40, 64'h4, 64'h302, 1'b1, 64'h306, 1'b1};
        vecs[5] = '{BR_JAL, 1'b0, 64'h10, 64'h12, 64'h999, 1'b1, 64'h22, 1'b1};
        vecs[6] = '{BR_COND, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 1'b1, 64'h10, 1'b0};

        rstn           = 1'b0;
        imem_req_ready = 1'b0;
        backend_stall  = 1'b0;
        set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);

        // Reset state
        advance();
        sample();
        chk("rst_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_addr", imem_req_addr, 64'h0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_stale", {63'd0, stale_accept}, 64'd0);
        chk("rst_rpc", redirect_pc, 64'h0);
        advance();

        // Sequential fetch after release
        rstn           = 1'b1;
        imem_req_ready = 1'b1;
        mpc            = 64'h0;
        for (int i = 0; i < 3; i++) begin
            push(mpc, 1'b0);
            sample();
            chk("seq_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("seq_flush", {63'd0, flush}, 64'd0);
            advance();
            mpc = mpc + 64'd4;
        end

        // Branch vector table, ready=1 throughout
        for (int i = 0; i < 7; i++) begin
            set_ex(1'b1, vecs[i].t, vecs[i].cmp, vecs[i].pc, vecs[i].imm, vecs[i].rs1);
            push(mpc, 1'b0);
            sample();
            chk("vec_flush", {63'd0, flush}, {63'd0, vecs[i].exp_flush});
            if (vecs[i].exp_flush) begin
                chk("vec_rpc", redirect_pc, vecs[i].exp_rpc);
                chk("vec_mis", {63'd0, redirect_misalign}, {63'd0, vecs[i].exp_mis});
            end
            advance();
            mpc = vecs[i].exp_flush ? vecs[i].exp_rpc : mpc + 64'd4;
        end
        set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);

        // JAL while ready=0 for 3 cycles: address held, stale accept, then target
        imem_req_ready = 1'b0;
        set_ex(1'b1, BR_JAL, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0);
        sample();
        chk("jal_flush", {63'd0, flush}, 64'd1);
        chk("jal_rpc", redirect_pc, 64'h1F8);
        chk("jal_hold0", imem_req_addr, mpc);
        advance();
        set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("jal_hold", imem_req_addr, mpc);
            chk("jal_noflush", {63'd0, flush}, 64'd0);
            advance();
        end
        imem_req_ready = 1'b1;
        push(mpc, 1'b1);
        sample();
        advance();
        push(64'h1F8, 1'b0);
        sample();
        advance();
        mpc = 64'h1FC;

        // backend_stall suppresses a taken JAL for 2 cycles, then it fires once
`ifdef BRANCH_PERF_EN
        br0 = br_cnt;
        tk0 = taken_cnt;
`endif
        flush_seen = 0;
        set_ex(1'b1, BR_JAL, 1'b0, 64'h40, 64'h40, 64'h0);
        backend_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) backend_stall = 1'b0;
            if (i == 3) set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);
            push(mpc, 1'b0);
            sample();
            if (flush) flush_seen++;
            advance();
            mpc = (i == 2) ? 64'h80 : mpc + 64'd4;
        end
        chk("stall_flush_cnt", 64'(flush_seen), 64'd1);
`ifdef BRANCH_PERF_EN
        chk("perf_br", {32'd0, br_cnt - br0}, 64'd1);
        chk("perf_taken", {32'd0, taken_cnt - tk0}, 64'd1);
`endif

        // Back-to-back taken in REDIR_WAIT; third taken coincides with accept
        imem_req_ready = 1'b0;
        set_ex(1'b1, BR_JAL, 1'b0, 64'h600, 64'h0, 64'h0);
        sample();
        advance();
        set_ex(1'b1, BR_JAL, 1'b0, 64'h700, 64'h0, 64'h0);
        sample();
        chk("rw_flush2", {63'd0, flush}, 64'd1);
        chk("rw_hold", imem_req_addr, mpc);
        advance();
        imem_req_ready = 1'b1;
        set_ex(1'b1, BR_JAL, 1'b0, 64'h800, 64'h0, 64'h0);
        push(mpc, 1'b1);
        sample();
        advance();
        set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);
        push(64'h800, 1'b0);
        sample();
        advance();
        mpc = 64'h804;

        // Reset while REDIR_WAIT holds 0x500: target must never be fetched
        imem_req_ready = 1'b0;
        set_ex(1'b1, BR_JAL, 1'b0, 64'h500, 64'h0, 64'h0);
        sample();
        chk("pend_flush", {63'd0, flush}, 64'd1);
        advance();
        set_ex(1'b0, BR_NONE, 1'b0, 64'h0, 64'h0, 64'h0);
        rstn = 1'b0;
        sample();
        chk("rw_rst_valid", {63'd0, imem_req_valid}, 64'd0);
        advance();
        rstn           = 1'b1;
        imem_req_ready = 1'b1;
        push(64'h0, 1'b0);
        sample();
        chk("rel_valid", {63'd0, imem_req_valid}, 64'd1);
        advance();
        push(64'h4, 1'b0);
        sample();
        advance();
`ifdef BRANCH_PERF_EN
        chk("perf_clr", {32'd0, br_cnt}, 64'd0);
`endif

        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
